edge_map_packer: RTL and testbench



---
 rtl/edge_pkg.sv | 27 ++
 rtl/edge_map_packer_if.sv | 11 +
 rtl/byte_fifo.sv | 55 +++++
 rtl/edge_map_packer.sv | 151 +++++++++++++++
 tb/tb_edge_map_packer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detector receive path: FSM states,
// FIFO entry layout and the default image geometry.
package edge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // FIFO entry layout: {eof, eol, byte}
  localparam int ENT_BYTE_LSB = 0;
  localparam int ENT_EOL      = 8;
  localparam int ENT_EOF      = 9;
  localparam int ENT_W        = 10;

  // Image geometry used by the edge detector
  localparam int DEF_IMG_WIDTH  = 256;
  localparam int DEF_IMG_HEIGHT = 256;

  function automatic logic [ENT_W-1:0] pack_entry(input logic eof, input logic eol,
                                                  input logic [7:0] b);
    return {eof, eol, b};
  endfunction

endpackage

// File: rtl/edge_map_packer_if.sv
// Byte stream produced by the edge map packer: tagged bytes over valid/ready.
interface edge_map_packer_if;
  logic [7:0] byte_out;
  logic       byte_eol;
  logic       byte_eof;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_out, byte_eol, byte_eof, byte_valid, input byte_ready);
  modport slave  (input byte_out, byte_eol, byte_eof, byte_valid, output byte_ready);
endinterface

// File: rtl/byte_fifo.sv
// Small show-ahead FIFO. The head entry is always presented on dout.
// A push on a full FIFO is accepted only if a pop happens in the same cycle;
// otherwise it is dropped and reported on drop.
module byte_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             full, do_pop, do_push;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign dout    = mem[rd_q];

  // Storage, pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_q] <= din;
        wr_q      <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/edge_map_packer.sv
// Packs the edge detector's serial edge stream MSB-first into bytes, tags
// row and frame ends, and hands the bytes out through a small FIFO.
module edge_map_packer
  import edge_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              bit_in,
  input  logic              complete_in,
  edge_map_packer_if.master bus,
  output logic              overflow,
  output logic              short_frame,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [7:0]       sreg_q, sreg_d;
  logic             ovf_q, short_q;

  logic             take, last_col, last_row, last_px, closing, early;
  logic [7:0]       byte_next;
  logic             push, push_eol, push_eof, short_set;
  logic [7:0]       push_byte;

  logic [ENT_W-1:0] head;
  logic             fifo_empty, fifo_drop, pop;

  assign last_col = (col_q == LAST_COL);
  assign last_row = (row_q == LAST_ROW);
  assign last_px  = last_col && last_row;
  assign take     = enb && ((state_q == ST_IDLE) || (state_q == ST_CAPTURE));
  assign closing  = (bcnt_q == 3'd7) || last_col;
  // complete_in on the very last pixel is an ordinary frame end, not a short one
  assign early    = complete_in && (state_q == ST_CAPTURE) && !(take && last_px);

  // Next-state, counter and byte-closure logic
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    bcnt_d    = bcnt_q;
    sreg_d    = sreg_q;
    push      = 1'b0;
    push_byte = 8'h00;
    push_eol  = 1'b0;
    push_eof  = 1'b0;
    short_set = 1'b0;
    byte_next = sreg_q;
    byte_next[3'd7 - bcnt_q] = bit_in;

    if (take) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (closing) begin
        push      = 1'b1;
        push_byte = byte_next;
        push_eol  = last_col;
        push_eof  = last_px;
        sreg_d    = 8'h00;
        bcnt_d    = 3'd0;
      end else begin
        sreg_d = byte_next;
        bcnt_d = bcnt_q + 1'b1;
      end
      state_d = last_px ? ST_FLUSH : ST_CAPTURE;
    end

    // The bit of this cycle (if any) is already folded in; close out the frame.
    if (early) begin
      short_set = 1'b1;
      state_d   = ST_FLUSH;
      push      = 1'b1;
      push_eof  = 1'b1;
      if (!(take && closing)) begin
        // Pending bits (or none, giving a zero byte) become the final byte
        push_eol  = 1'b0;
        push_byte = take ? byte_next : sreg_q;
        sreg_d    = 8'h00;
        bcnt_d    = 3'd0;
      end
    end

    if ((state_q == ST_FLUSH) && fifo_empty) state_d = ST_DONE;
  end

  // State, counters, shift register and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      bcnt_q  <= 3'd0;
      sreg_q  <= 8'h00;
      ovf_q   <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      bcnt_q  <= bcnt_d;
      sreg_q  <= sreg_d;
      ovf_q   <= ovf_q | fifo_drop;
      short_q <= short_q | short_set;
    end
  end

  assign pop = bus.byte_valid && bus.byte_ready;

  byte_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .din   (pack_entry(push_eof, push_eol, push_byte)),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign bus.byte_valid = !fifo_empty;
  assign bus.byte_out   = fifo_empty ? 8'h00 : head[ENT_BYTE_LSB +: 8];
  assign bus.byte_eol   = !fifo_empty && head[ENT_EOL];
  assign bus.byte_eof   = !fifo_empty && head[ENT_EOF];

  assign overflow    = ovf_q;
  assign short_frame = short_q;
  assign busy        = (state_q == ST_CAPTURE) || (state_q == ST_FLUSH);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_edge_map_packer.sv
// Directed bench for edge_map_packer. Four instances cover different image
// geometries: u0 16x2, u1 8x1, u2 12x1, u3 64x1 (all FIFO_DEPTH=4).
module tb_edge_map_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [4];
  logic       enb [4];
  logic       bin [4];
  logic       cmp [4];
  logic       rdy [4];
  logic       vld [4];
  logic [7:0] bo  [4];
  logic       eol [4];
  logic       eof [4];
  logic       ovf [4];
  logic       shf [4];
  logic       bsy [4];
  logic       dn  [4];

  int vectors     = 0;
  int miscompares = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];
  logic [9:0] q3[$];

  edge_map_packer_if if0 ();
  edge_map_packer_if if1 ();
  edge_map_packer_if if2 ();
  edge_map_packer_if if3 ();

  assign if0.byte_ready = rdy[0];
  assign if1.byte_ready = rdy[1];
  assign if2.byte_ready = rdy[2];
  assign if3.byte_ready = rdy[3];
  assign vld[0] = if0.byte_valid; assign bo[0] = if0.byte_out;
  assign vld[1] = if1.byte_valid; assign bo[1] = if1.byte_out;
  assign vld[2] = if2.byte_valid; assign bo[2] = if2.byte_out;
  assign vld[3] = if3.byte_valid; assign bo[3] = if3.byte_out;
  assign eol[0] = if0.byte_eol;   assign eof[0] = if0.byte_eof;
  assign eol[1] = if1.byte_eol;   assign eof[1] = if1.byte_eof;
  assign eol[2] = if2.byte_eol;   assign eof[2] = if2.byte_eof;
  assign eol[3] = if3.byte_eol;   assign eof[3] = if3.byte_eof;

  edge_map_packer #(.IMG_WIDTH(16), .IMG_HEIGHT(2), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .reset(rst[0]), .enb(enb[0]), .bit_in(bin[0]), .complete_in(cmp[0]),
    .bus(if0), .overflow(ovf[0]), .short_frame(shf[0]), .busy(bsy[0]), .done(dn[0]));
  edge_map_packer #(.IMG_WIDTH(8), .IMG_HEIGHT(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .reset(rst[1]), .enb(enb[1]), .bit_in(bin[1]), .complete_in(cmp[1]),
    .bus(if1), .overflow(ovf[1]), .short_frame(shf[1]), .busy(bsy[1]), .done(dn[1]));
  edge_map_packer #(.IMG_WIDTH(12), .IMG_HEIGHT(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .reset(rst[2]), .enb(enb[2]), .bit_in(bin[2]), .complete_in(cmp[2]),
    .bus(if2), .overflow(ovf[2]), .short_frame(shf[2]), .busy(bsy[2]), .done(dn[2]));
  edge_map_packer #(.IMG_WIDTH(64), .IMG_HEIGHT(1), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .reset(rst[3]), .enb(enb[3]), .bit_in(bin[3]), .complete_in(cmp[3]),
    .bus(if3), .overflow(ovf[3]), .short_frame(shf[3]), .busy(bsy[3]), .done(dn[3]));

  // Record every accepted byte as {eof, eol, byte}
  always @(posedge clk) if (if0.byte_valid && if0.byte_ready) q0.push_back({if0.byte_eof, if0.byte_eol, if0.byte_out});
  always @(posedge clk) if (if1.byte_valid && if1.byte_ready) q1.push_back({if1.byte_eof, if1.byte_eol, if1.byte_out});
  always @(posedge clk) if (if2.byte_valid && if2.byte_ready) q2.push_back({if2.byte_eof, if2.byte_eol, if2.byte_out});
  always @(posedge clk) if (if3.byte_valid && if3.byte_ready) q3.push_back({if3.byte_eof, if3.byte_eol, if3.byte_out});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int u);
    case (u)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [9:0] qget(input int u, input int i);
    case (u)
      0: return q0[i];
      1: return q1[i];
      2: return q2[i];
      default: return q3[i];
    endcase
  endfunction

  // Compare the first n recorded entries of unit u with the expected list
  task automatic chk_q(input int u, input string tag, input int n,
                       input logic [9:0] e0, input logic [9:0] e1,
                       input logic [9:0] e2, input logic [9:0] e3);
    logic [9:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    chk({tag, ".count"}, qsize(u), n);
    for (int i = 0; i < n; i++)
      if (i < qsize(u)) chk($sformatf("%s[%0d]", tag, i), qget(u, i), exp[i]);
  endtask

  // One bit per cycle; inputs change on the falling edge
  task automatic send(input int u, input logic b);
    enb[u] = 1'b1;
    bin[u] = b;
    @(negedge clk);
    enb[u] = 1'b0;
    bin[u] = 1'b0;
  endtask

  task automatic send_n(input int u, input int n, input logic b);
    for (int i = 0; i < n; i++) send(u, b);
  endtask

  task automatic wait_done(input int u, input string tag);
    int n = 0;
    while (!dn[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, dn[u], 1);
  endtask

  task automatic pulse_reset(input int u);
    rst[u] = 1'b1;
    @(negedge clk);
    rst[u] = 1'b0;
  endtask

  task automatic chk_idle(input int u, input string tag);
    chk({tag, ".valid"}, vld[u], 0);
    chk({tag, ".byte"},  bo[u],  8'h00);
    chk({tag, ".busy"},  bsy[u], 0);
    chk({tag, ".done"},  dn[u],  0);
    chk({tag, ".ovf"},   ovf[u], 0);
    chk({tag, ".short"}, shf[u], 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; enb[i] = 1'b0; bin[i] = 1'b0; cmp[i] = 1'b0; rdy[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk_idle(0, "rst0");
    chk_idle(3, "rst3");
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    @(negedge clk);

    // 16x2 full frame of ones, consumer always ready
    rdy[0] = 1'b1;
    send(0, 1'b1);
    chk("t1.busy", bsy[0], 1);
    send_n(0, 31, 1'b1);
    wait_done(0, "t1.done");
    chk_q(0, "t1.q", 4, 10'h0FF, 10'h1FF, 10'h0FF, 10'h3FF);
    chk("t1.ovf",   ovf[0], 0);
    chk("t1.short", shf[0], 0);
    chk("t1.busy2", bsy[0], 0);

    // 8x1 alternating bits; byte must appear one cycle after the 8th bit
    send(1, 1'b1); send(1, 1'b0); send(1, 1'b1); send(1, 1'b0);
    send(1, 1'b1); send(1, 1'b0); send(1, 1'b1);
    chk("t2.valid7", vld[1], 0);
    send(1, 1'b0);
    chk("t2.valid8", vld[1], 1);
    chk("t2.byte",   bo[1],  8'hAA);
    chk("t2.eol",    eol[1], 1);
    chk("t2.eof",    eof[1], 1);
    chk("t2.done0",  dn[1],  0);
    rdy[1] = 1'b1;
    wait_done(1, "t2.done");
    chk_q(1, "t2.q", 1, 10'h3AA, 10'h0, 10'h0, 10'h0);

    // 12x1 ones: second byte is padded and closes the row and frame
    rdy[2] = 1'b1;
    send_n(2, 12, 1'b1);
    wait_done(2, "t3.done");
    chk_q(2, "t3.q", 2, 10'h0FF, 10'h3F0, 10'h0, 10'h0);

    // 64x1 ones with a stalled consumer: FIFO fills, later bytes are dropped
    send_n(3, 32, 1'b1);
    chk("t4.valid", vld[3], 1);
    chk("t4.ovf32", ovf[3], 0);
    send_n(3, 8, 1'b1);
    chk("t4.ovf40", ovf[3], 1);
    send_n(3, 24, 1'b1);
    rdy[3] = 1'b1;
    wait_done(3, "t4.done");
    chk_q(3, "t4.q", 4, 10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF);
    chk("t4.ovf_sticky", ovf[3], 1);

    // 16x2 frame cut short after five ones
    pulse_reset(0);
    q0.delete();
    chk_idle(0, "t5.rst");
    send_n(0, 5, 1'b1);
    cmp[0] = 1'b1;
    @(negedge clk);
    cmp[0] = 1'b0;
    chk("t5.short", shf[0], 1);
    wait_done(0, "t5.done");
    chk_q(0, "t5.q", 1, 10'h2F8, 10'h0, 10'h0, 10'h0);

    // Reset in the middle of a frame, then a clean frame
    pulse_reset(0);
    q0.delete();
    rdy[0] = 1'b0;
    send_n(0, 20, 1'b1);
    chk("t6.valid_pre", vld[0], 1);
    chk("t6.busy_pre",  bsy[0], 1);
    pulse_reset(0);
    chk("t6.valid_rst", vld[0], 0);
    chk("t6.busy_rst",  bsy[0], 0);
    chk("t6.short_rst", shf[0], 0);
    q0.delete();
    rdy[0] = 1'b1;
    send_n(0, 32, 1'b1);
    wait_done(0, "t6.done");
    chk_q(0, "t6.q", 4, 10'h0FF, 10'h1FF, 10'h0FF, 10'h3FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
